magic_buttons: RTL and testbench

- Front-end conditioning stage for the magic/pause controls. It sits between the raw board button and the decoded PS/2 key levels on one side, and the magic-mode controller's magic_button/pause_button inputs on the other.
- Synchronises and debounces the physical button and classifies each press as short (magic request) or long (reboot request).
- Holds each request until the next frame-interrupt edge, so the controller, which samples only on that edge, never misses it.

---
 rtl/magic_buttons.sv | 179 +++++++++++++++++
 tb/tb_magic_buttons.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/magic_buttons.sv
// rtl/magic_buttons.sv - magic/pause button conditioning with frame-held requests
module magic_buttons #(
    parameter int TICK_DIV       = 28000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int LONG_TICKS     = 1000
) (
    input  logic rst_n,
    input  logic clk28,
    input  logic btn_n,
    input  logic key_magic,
    input  logic key_pause,
    input  logic n_int,
    input  logic n_int_next,
    output logic magic_button,
    output logic pause_button,
    output logic reboot_req,
    output logic btn_pressed
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_TICKS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_LONG = 2'd2;

    logic          sync1;
    logic          sync2;
    logic          raw_pressed;
    logic [PW-1:0] presc;
    logic          tick;
    logic [DW-1:0] deb_cnt;
    logic [1:0]    state;
    logic [HW-1:0] hold_cnt;
    logic          magic_req;
    logic          pause_req;
    logic          key_magic_q;
    logic          key_pause_q;
    logic          short_press;
    logic          long_hit;
    logic          frame_edge;
    logic          magic_set;
    logic          pause_set;

    assign raw_pressed = ~sync2;
    assign tick        = (presc == PRESC_LAST);
    assign frame_edge  = n_int & ~n_int_next;

    // A short press is recognised on the first cycle HELD sees the clean level released
    assign short_press = (state == ST_HELD) && !btn_pressed;
    assign long_hit    = (state == ST_HELD) && btn_pressed && tick && (hold_cnt == HOLD_LAST);

    // Short press and a key edge in the same cycle merge into one request
    assign magic_set   = short_press | (key_magic & ~key_magic_q);
    assign pause_set   = key_pause & ~key_pause_q;

    // Two-stage synchroniser for the asynchronous button pin; idle level is released
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    // Millisecond tick prescaler
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Debounce: count ticks of disagreement, flip the clean level once the window is met
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt     <= '0;
            btn_pressed <= 1'b0;
        end else if (raw_pressed == btn_pressed) begin
            deb_cnt <= '0;
        end else if (tick) begin
            if (deb_cnt == DEB_LAST) begin
                deb_cnt     <= '0;
                btn_pressed <= raw_pressed;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Press classifier: time the hold, pulse reboot once, then wait out the release
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            reboot_req <= 1'b0;
        end else begin
            reboot_req <= long_hit;
            case (state)
                ST_IDLE: begin
                    if (btn_pressed) begin
                        state    <= ST_HELD;
                        hold_cnt <= '0;
                    end
                end
                ST_HELD: begin
                    if (!btn_pressed) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (long_hit) begin
                            state <= ST_LONG;
                        end
                    end
                end
                ST_LONG: begin
                    // hold_cnt is frozen here, so it cannot wrap on very long holds
                    if (!btn_pressed) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Previous-cycle key levels for edge detection
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            key_magic_q <= 1'b0;
            key_pause_q <= 1'b0;
        end else begin
            key_magic_q <= key_magic;
            key_pause_q <= key_pause;
        end
    end

    // Request latches: held until a frame edge consumes them, a new set beats the clear
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            magic_req <= 1'b0;
            pause_req <= 1'b0;
        end else begin
            if (magic_set) begin
                magic_req <= 1'b1;
            end else if (frame_edge) begin
                magic_req <= 1'b0;
            end
            if (pause_set) begin
                pause_req <= 1'b1;
            end else if (frame_edge) begin
                pause_req <= 1'b0;
            end
        end
    end

    // Registered controller-facing outputs; key levels pass through so release is visible
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            magic_button <= 1'b0;
            pause_button <= 1'b0;
        end else begin
            magic_button <= magic_req | key_magic;
            pause_button <= pause_req | key_pause;
        end
    end

endmodule

// File: tb/tb_magic_buttons.sv
// tb/tb_magic_buttons.sv - self-checking bench for magic_buttons
module tb_magic_buttons;
    localparam int TD = 4;
    localparam int DT = 3;
    localparam int LT = 20;

    logic rst_n      = 1'b1;
    logic clk28      = 1'b0;
    logic btn_n      = 1'b1;
    logic key_magic  = 1'b0;
    logic key_pause  = 1'b0;
    logic n_int      = 1'b1;
    logic n_int_next = 1'b1;
    logic magic_button;
    logic pause_button;
    logic reboot_req;
    logic btn_pressed;

    int n_vec = 0;
    int n_err = 0;

    magic_buttons #(
        .TICK_DIV      (TD),
        .DEBOUNCE_TICKS(DT),
        .LONG_TICKS    (LT)
    ) dut (
        .rst_n       (rst_n),
        .clk28       (clk28),
        .btn_n       (btn_n),
        .key_magic   (key_magic),
        .key_pause   (key_pause),
        .n_int       (n_int),
        .n_int_next  (n_int_next),
        .magic_button(magic_button),
        .pause_button(pause_button),
        .reboot_req  (reboot_req),
        .btn_pressed (btn_pressed)
    );

    always #5 clk28 = ~clk28;

    typedef struct packed {
        logic km;
        logic kp;
        logic ni;
        logic nn;
        logic exp_mb;
        logic exp_pb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit km, bit kp, bit ni, bit nn, bit emb, bit epb);
        vec_t v;
        v.km = km; v.kp = kp; v.ni = ni; v.nn = nn; v.exp_mb = emb; v.exp_pb = epb;
        return v;
    endfunction

    // Reference model state: history of button samples, elapsed-cycle tick timing,
    // press timing in ticks and the two pending requests.
    bit m_h1, m_h2, m_pressed, m_in_press, m_long, m_mreq, m_preq, m_km_q, m_kp_q;
    bit m_mb, m_pb, m_rb;
    int m_cyc, m_deb, m_hold;

    task automatic model_reset();
        m_h1 = 1; m_h2 = 1; m_pressed = 0; m_in_press = 0; m_long = 0;
        m_mreq = 0; m_preq = 0; m_km_q = 0; m_kp_q = 0;
        m_mb = 0; m_pb = 0; m_rb = 0;
        m_cyc = 0; m_deb = 0; m_hold = 0;
    endtask

    task automatic model_step();
        bit raw_down, tick_now, fe, short_ev, long_ev, next_pressed;
        raw_down     = !m_h2;
        tick_now     = (m_cyc % TD) == TD - 1;
        fe           = n_int && !n_int_next;
        short_ev     = 0;
        long_ev      = 0;
        next_pressed = m_pressed;
        if (raw_down == m_pressed) begin
            m_deb = 0;
        end else if (tick_now) begin
            m_deb++;
            if (m_deb == DT) begin
                next_pressed = raw_down;
                m_deb = 0;
            end
        end
        if (!m_in_press) begin
            if (m_pressed) begin
                m_in_press = 1; m_long = 0; m_hold = 0;
            end
        end else if (!m_long) begin
            if (!m_pressed) begin
                m_in_press = 0; short_ev = 1;
            end else if (tick_now) begin
                m_hold++;
                if (m_hold == LT) begin
                    long_ev = 1; m_long = 1;
                end
            end
        end else if (!m_pressed) begin
            m_in_press = 0;
        end
        m_mb = m_mreq || key_magic;
        m_pb = m_preq || key_pause;
        m_rb = long_ev;
        if (short_ev || (key_magic && !m_km_q)) m_mreq = 1;
        else if (fe) m_mreq = 0;
        if (key_pause && !m_kp_q) m_preq = 1;
        else if (fe) m_preq = 0;
        m_km_q    = key_magic;
        m_kp_q    = key_pause;
        m_pressed = next_pressed;
        m_h2      = m_h1;
        m_h1      = btn_n;
        m_cyc++;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(string name, int act, int lo, int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cycle();
        @(posedge clk28);
        model_step();
        @(negedge clk28);
        check("magic_button", {31'd0, magic_button}, {31'd0, m_mb});
        check("pause_button", {31'd0, pause_button}, {31'd0, m_pb});
        check("reboot_req",   {31'd0, reboot_req},   {31'd0, m_rb});
        check("btn_pressed",  {31'd0, btn_pressed},  {31'd0, m_pressed});
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset magic_button", {31'd0, magic_button}, 32'd0);
        check("reset pause_button", {31'd0, pause_button}, 32'd0);
        check("reset reboot_req",   {31'd0, reboot_req},   32'd0);
        check("reset btn_pressed",  {31'd0, btn_pressed},  32'd0);
        model_reset();
        @(posedge clk28);
        @(negedge clk28);
        rst_n = 1'b1;
    endtask

    task automatic frame_pulse();
        n_int_next = 1'b0;
        cycle();
        n_int      = 1'b0;
        n_int_next = 1'b1;
        cycle();
        n_int      = 1'b1;
        cycle();
    endtask

    initial begin
        int lat, rise_at, reb_at, reb_cnt, seen_bp, seen_mb, seen_rb, low_cnt, len;

        // Key/frame table: {key_magic, key_pause, n_int, n_int_next, exp magic, exp pause}
        tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0));

        #2;
        do_reset();

        foreach (tbl[i]) begin
            key_magic  = tbl[i].km;
            key_pause  = tbl[i].kp;
            n_int      = tbl[i].ni;
            n_int_next = tbl[i].nn;
            cycle();
            check("table magic_button", {31'd0, magic_button}, {31'd0, tbl[i].exp_mb});
            check("table pause_button", {31'd0, pause_button}, {31'd0, tbl[i].exp_pb});
        end
        key_magic = 0; key_pause = 0; n_int = 1; n_int_next = 1;
        run(4);

        // Bounce shorter than the debounce window
        seen_bp = 0; seen_mb = 0; seen_rb = 0;
        for (int i = 0; i < 12; i++) begin
            btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (5) begin
                cycle();
                seen_bp |= int'(btn_pressed); seen_mb |= int'(magic_button); seen_rb |= int'(reboot_req);
            end
        end
        btn_n = 1'b1;
        repeat (20) begin
            cycle();
            seen_bp |= int'(btn_pressed); seen_mb |= int'(magic_button); seen_rb |= int'(reboot_req);
        end
        check("bounce btn_pressed", seen_bp, 0);
        check("bounce magic_button", seen_mb, 0);
        check("bounce reboot_req", seen_rb, 0);

        // Short press, held across frame-less time, consumed by one frame edge
        btn_n = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (btn_pressed && lat < 0) lat = i;
        end
        check_range("short press debounce latency", lat, 10, 15);
        btn_n = 1'b1;
        lat = -1;
        for (int i = 1; i <= 30 && lat < 0; i++) begin
            cycle();
            if (magic_button) lat = i;
        end
        check_range("short press magic latency", lat, 1, 30);
        low_cnt = 0;
        repeat (40) begin
            cycle();
            if (!magic_button) low_cnt++;
        end
        check("short press magic held", low_cnt, 0);
        frame_pulse();
        check("short press magic consumed", {31'd0, magic_button}, 32'd0);

        // Long press: single reboot pulse, no magic on release
        btn_n = 1'b0;
        rise_at = -1; reb_at = -1; reb_cnt = 0;
        for (int i = 1; i <= 120; i++) begin
            cycle();
            if (btn_pressed && rise_at < 0) rise_at = i;
            if (reboot_req) begin
                reb_cnt++;
                reb_at = i;
            end
        end
        check("long press reboot pulses", reb_cnt, 1);
        check_range("long press reboot latency", reb_at - rise_at, 76, 85);
        btn_n = 1'b1;
        seen_mb = 0;
        repeat (30) begin
            cycle();
            seen_mb |= int'(magic_button);
        end
        check("long press no magic", seen_mb, 0);
        check("long press released", {31'd0, btn_pressed}, 32'd0);

        // One-cycle magic key pulse latched until a frame edge
        key_magic = 1'b1;
        cycle();
        key_magic = 1'b0;
        run(10);
        check("key magic latched", {31'd0, magic_button}, 32'd1);
        frame_pulse();
        check("key magic consumed", {31'd0, magic_button}, 32'd0);

        // Pause key held across a frame edge keeps the level
        key_pause = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 47; i++) begin
            if (i == 20) frame_pulse();
            else cycle();
            if (!pause_button && i > 0) low_cnt++;
        end
        check("pause level held", low_cnt, 0);
        key_pause = 1'b0;
        cycle();
        check("pause dropped", {31'd0, pause_button}, 32'd0);

        // Magic key edge coinciding with a frame edge while already pending
        key_magic = 1'b1;
        cycle();
        key_magic = 1'b0;
        run(3);
        key_magic  = 1'b1;
        n_int_next = 1'b0;
        cycle();
        key_magic  = 1'b0;
        n_int      = 1'b0;
        n_int_next = 1'b1;
        cycle();
        n_int = 1'b1;
        run(10);
        check("coincident set survives", {31'd0, magic_button}, 32'd1);
        frame_pulse();
        check("coincident set consumed", {31'd0, magic_button}, 32'd0);

        // Reset in the middle of a held press
        btn_n = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30 && lat < 0; i++) begin
            cycle();
            if (btn_pressed) lat = i;
        end
        check_range("pre-reset press latency", lat, 10, 15);
        run(10);
        do_reset();
        lat = -1;
        for (int i = 1; i <= 30 && lat < 0; i++) begin
            cycle();
            if (btn_pressed) lat = i;
        end
        check_range("post-reset press latency", lat, 10, 15);
        reb_at = -1;
        for (int i = 1; i <= 120 && reb_at < 0; i++) begin
            cycle();
            if (reboot_req) reb_at = i;
        end
        check_range("post-reset reboot latency", reb_at, 76, 85);
        btn_n = 1'b1;
        run(30);

        // Randomised traffic against the model
        for (int seg = 0; seg < 60; seg++) begin
            btn_n = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 100));
            for (int c = 0; c < len; c++) begin
                key_magic = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 29) == 0) key_pause = ~key_pause;
                n_int      = n_int_next;
                n_int_next = (n_int && $urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
                cycle();
            end
        end
        key_magic = 0; key_pause = 0; btn_n = 1; n_int = 1; n_int_next = 1;
        run(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
